// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register for the control/datapath bundle.
// SKID=1 gives a two-entry stage with registered in_ready; SKID=0 a single entry.
module pipe_stage_elastic #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 133,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam bit LP_SKID = (SKID != 0);

    logic              r_main_v;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_v;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_occ;
    logic              r_in_ready;

    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_main_free;

    logic              w_main_v_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_v_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [1:0]        w_occ_nxt;
    logic              w_in_ready_nxt;

    // Single-entry mode passes backpressure straight through.
    assign w_in_ready  = LP_SKID ? r_in_ready : (out_ready | ~r_main_v);
    assign w_in_xfer   = in_valid & w_in_ready;
    assign w_out_xfer  = r_main_v & out_ready;
    assign w_main_free = ~r_main_v | out_ready;

    always_comb begin
        w_main_v_nxt    = r_main_v;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_v_nxt    = r_skid_v;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_occ_nxt       = r_occ;
        w_in_ready_nxt  = r_in_ready;
        if (flush) begin
            w_main_v_nxt    = 1'b0;
            w_main_ctrl_nxt = '0;
            w_skid_v_nxt    = 1'b0;
            w_skid_ctrl_nxt = '0;
            w_occ_nxt       = 2'd0;
            w_in_ready_nxt  = 1'b1;
        end else begin
            if (w_main_free) begin
                if (r_skid_v) begin
                    w_main_v_nxt    = 1'b1;
                    w_main_ctrl_nxt = r_skid_ctrl;
                    w_main_data_nxt = r_skid_data;
                    if (w_in_xfer) begin
                        w_skid_v_nxt    = 1'b1;
                        w_skid_ctrl_nxt = in_ctrl;
                        w_skid_data_nxt = in_data;
                    end else begin
                        w_skid_v_nxt    = 1'b0;
                        w_skid_ctrl_nxt = '0;
                    end
                end else if (w_in_xfer) begin
                    w_main_v_nxt    = 1'b1;
                    w_main_ctrl_nxt = in_ctrl;
                    w_main_data_nxt = in_data;
                end else begin
                    w_main_v_nxt    = 1'b0;
                    w_main_ctrl_nxt = '0;
                end
            end else if (w_in_xfer && LP_SKID) begin
                // Main is stalled: park the newcomer behind it.
                w_skid_v_nxt    = 1'b1;
                w_skid_ctrl_nxt = in_ctrl;
                w_skid_data_nxt = in_data;
            end
            w_occ_nxt      = r_occ + 2'(w_in_xfer) - 2'(w_out_xfer);
            w_in_ready_nxt = ~w_occ_nxt[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_v    <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_v    <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_occ       <= 2'd0;
            r_in_ready  <= 1'b1;
        end else begin
            r_main_v    <= w_main_v_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_v    <= w_skid_v_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_occ       <= w_occ_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_main_v;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and queue-checked random bench for pipe_stage_elastic,
// one instance per SKID setting.
module tb_pipe_stage_elastic;

    logic clk;
    logic rst;
    logic flush;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [5:0]   s_in_ctrl, s_out_ctrl;
    logic [132:0] s_in_data, s_out_data;
    logic [1:0]   s_occ;

    logic         f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [5:0]   f_in_ctrl, f_out_ctrl;
    logic [132:0] f_in_data, f_out_data;
    logic [1:0]   f_occ;

    int n_checks;
    int n_fail;

    logic [37:0] sq[$];
    logic [37:0] fq[$];
    logic [31:0] s_tag;
    logic [31:0] f_tag;

    pipe_stage_elastic #(.CTRL_W(6), .DATA_W(133), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occ)
    );

    pipe_stage_elastic #(.CTRL_W(6), .DATA_W(133), .SKID(0)) u_flow (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_ctrl(f_in_ctrl), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_ctrl(f_out_ctrl), .out_data(f_out_data),
        .occupancy(f_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [159:0] got,
                            input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_offer(input logic v, input logic [5:0] c, input logic [31:0] d);
        s_in_valid = v;
        s_in_ctrl  = c;
        s_in_data  = {101'd0, d};
    endtask

    task automatic f_offer(input logic v, input logic [5:0] c, input logic [31:0] d);
        f_in_valid = v;
        f_in_ctrl  = c;
        f_in_data  = {101'd0, d};
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        s_offer(1'b0, 6'h00, 32'h0);
        f_offer(1'b0, 6'h00, 32'h0);
        s_out_ready = 1'b0;
        f_out_ready = 1'b0;
        #2;
        check_eq("rst_s_occ", 160'(s_occ), 160'd0);
        check_eq("rst_s_vld", 160'(s_out_valid), 160'd0);
        check_eq("rst_s_ctrl", 160'(s_out_ctrl), 160'd0);
        check_eq("rst_s_data", 160'(s_out_data), 160'd0);
        check_eq("rst_f_vld", 160'(f_out_valid), 160'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_s_rdy", 160'(s_in_ready), 160'd1);
        check_eq("rst_f_rdy", 160'(f_in_ready), 160'd1);

        // Streaming with out_ready held high
        s_out_ready = 1'b1;
        s_offer(1'b1, 6'h05, 32'd1);
        tick();
        check_eq("str1_data", 160'(s_out_data[31:0]), 160'd1);
        check_eq("str1_ctrl", 160'(s_out_ctrl), 160'h05);
        check_eq("str1_occ", 160'(s_occ), 160'd1);
        check_eq("str1_rdy", 160'(s_in_ready), 160'd1);
        s_offer(1'b1, 6'h06, 32'd2);
        tick();
        check_eq("str2_data", 160'(s_out_data[31:0]), 160'd2);
        check_eq("str2_occ", 160'(s_occ), 160'd1);
        check_eq("str2_rdy", 160'(s_in_ready), 160'd1);
        s_offer(1'b1, 6'h07, 32'd3);
        tick();
        check_eq("str3_data", 160'(s_out_data[31:0]), 160'd3);
        check_eq("str3_occ", 160'(s_occ), 160'd1);
        s_offer(1'b0, 6'h00, 32'd0);
        tick();
        check_eq("str_end_vld", 160'(s_out_valid), 160'd0);
        check_eq("str_end_ctrl", 160'(s_out_ctrl), 160'd0);
        check_eq("str_end_occ", 160'(s_occ), 160'd0);

        // Stall fills main then skid; third offer refused
        s_out_ready = 1'b0;
        s_offer(1'b1, 6'h0A, 32'hA);
        tick();
        s_offer(1'b1, 6'h0B, 32'hB);
        tick();
        check_eq("stl_occ2", 160'(s_occ), 160'd2);
        check_eq("stl_rdy0", 160'(s_in_ready), 160'd0);
        check_eq("stl_mainA", 160'(s_out_data[31:0]), 160'hA);
        s_offer(1'b1, 6'h0C, 32'hC);
        tick();
        check_eq("stl_hold_occ", 160'(s_occ), 160'd2);
        check_eq("stl_hold_data", 160'(s_out_data[31:0]), 160'hA);
        check_eq("stl_hold_ctrl", 160'(s_out_ctrl), 160'h0A);
        s_out_ready = 1'b1;
        tick();
        check_eq("drn_B", 160'(s_out_data[31:0]), 160'hB);
        check_eq("drn_B_occ", 160'(s_occ), 160'd1);
        check_eq("drn_B_rdy", 160'(s_in_ready), 160'd1);
        tick();
        check_eq("drn_C", 160'(s_out_data[31:0]), 160'hC);
        check_eq("drn_C_ctrl", 160'(s_out_ctrl), 160'h0C);
        s_offer(1'b0, 6'h00, 32'd0);
        tick();
        check_eq("drn_empty", 160'(s_occ), 160'd0);

        // Flush at occupancy 2 with an offer pending
        s_out_ready = 1'b0;
        s_offer(1'b1, 6'h0D, 32'hD);
        tick();
        s_offer(1'b1, 6'h0E, 32'hE);
        tick();
        check_eq("fl_pre_occ", 160'(s_occ), 160'd2);
        flush = 1'b1;
        s_offer(1'b1, 6'h0F, 32'hF);
        tick();
        check_eq("fl_occ", 160'(s_occ), 160'd0);
        check_eq("fl_vld", 160'(s_out_valid), 160'd0);
        check_eq("fl_ctrl", 160'(s_out_ctrl), 160'd0);
        check_eq("fl_rdy", 160'(s_in_ready), 160'd1);
        tick();
        check_eq("fl_ready_drop", 160'(s_out_valid), 160'd0);
        flush = 1'b0;
        s_offer(1'b0, 6'h00, 32'd0);
        s_out_ready = 1'b1;
        tick();
        check_eq("fl_no_ghost", 160'(s_out_valid), 160'd0);

        // Reset while an entry is stalled
        s_out_ready = 1'b0;
        s_offer(1'b1, 6'h3F, 32'h55);
        tick();
        check_eq("ar_pre_ctrl", 160'(s_out_ctrl), 160'h3F);
        s_offer(1'b0, 6'h00, 32'd0);
        #3 rst = 1'b0;
        #1;
        check_eq("ar_vld", 160'(s_out_valid), 160'd0);
        check_eq("ar_ctrl", 160'(s_out_ctrl), 160'd0);
        check_eq("ar_data", 160'(s_out_data), 160'd0);
        check_eq("ar_occ", 160'(s_occ), 160'd0);
        #1 rst = 1'b1;
        #1;
        check_eq("ar_rdy", 160'(s_in_ready), 160'd1);
        s_out_ready = 1'b1;
        tick();
        check_eq("ar_no_stale", 160'(s_out_valid), 160'd0);
        s_offer(1'b1, 6'h01, 32'h77);
        tick();
        check_eq("ar_new_data", 160'(s_out_data[31:0]), 160'h77);
        check_eq("ar_new_vld", 160'(s_out_valid), 160'd1);
        s_offer(1'b0, 6'h00, 32'd0);
        tick();

        // Single-entry stage: combinational backpressure
        f_out_ready = 1'b0;
        f_offer(1'b1, 6'h02, 32'h21);
        tick();
        check_eq("se_vld", 160'(f_out_valid), 160'd1);
        check_eq("se_rdy0", 160'(f_in_ready), 160'd0);
        check_eq("se_occ", 160'(f_occ), 160'd1);
        f_offer(1'b1, 6'h03, 32'h22);
        tick();
        check_eq("se_hold", 160'(f_out_data[31:0]), 160'h21);
        f_out_ready = 1'b1;
        #1;
        check_eq("se_rdy1", 160'(f_in_ready), 160'd1);
        tick();
        check_eq("se_repl_data", 160'(f_out_data[31:0]), 160'h22);
        check_eq("se_repl_ctrl", 160'(f_out_ctrl), 160'h03);
        check_eq("se_repl_occ", 160'(f_occ), 160'd1);
        f_offer(1'b0, 6'h00, 32'd0);
        tick();
        check_eq("se_empty_vld", 160'(f_out_valid), 160'd0);
        check_eq("se_empty_ctrl", 160'(f_out_ctrl), 160'd0);
        check_eq("se_empty_occ", 160'(f_occ), 160'd0);

        // Random traffic on both instances against reference queues
        rst = 1'b0;
        #1 rst = 1'b1;
        s_tag = 32'd100;
        f_tag = 32'd500;
        for (int i = 0; i < 320; i++) begin
            @(posedge clk);
            #1;
            if (i < 300) begin
                s_out_ready = 1'($urandom_range(0, 1));
                f_out_ready = 1'($urandom_range(0, 1));
                s_offer(1'($urandom_range(0, 1)), s_tag[5:0], s_tag);
                f_offer(1'($urandom_range(0, 1)), f_tag[5:0], f_tag);
            end else begin
                s_out_ready = 1'b1;
                f_out_ready = 1'b1;
                s_offer(1'b0, 6'h00, 32'd0);
                f_offer(1'b0, 6'h00, 32'd0);
            end
            @(negedge clk);
            check_eq("rs_occ", 160'(s_occ), 160'(sq.size()));
            check_eq("rs_vld", 160'(s_out_valid), 160'(sq.size() != 0));
            if (!s_out_valid)
                check_eq("rs_bubble", 160'(s_out_ctrl), 160'd0);
            if (s_out_valid && s_out_ready && sq.size() != 0) begin
                check_eq("rs_order", 160'({s_out_ctrl, s_out_data[31:0]}), 160'(sq[0]));
                void'(sq.pop_front());
            end
            if (s_in_valid && s_in_ready) begin
                sq.push_back({s_in_ctrl, s_in_data[31:0]});
                s_tag++;
            end
            check_eq("rf_occ", 160'(f_occ), 160'(fq.size()));
            check_eq("rf_vld", 160'(f_out_valid), 160'(fq.size() != 0));
            if (!f_out_valid)
                check_eq("rf_bubble", 160'(f_out_ctrl), 160'd0);
            if (f_out_valid && f_out_ready && fq.size() != 0) begin
                check_eq("rf_order", 160'({f_out_ctrl, f_out_data[31:0]}), 160'(fq[0]));
                void'(fq.pop_front());
            end
            if (f_in_valid && f_in_ready) begin
                fq.push_back({f_in_ctrl, f_in_data[31:0]});
                f_tag++;
            end
        end
        check_eq("rs_drained", 160'(sq.size()), 160'd0);
        check_eq("rf_drained", 160'(fq.size()), 160'd0);
        check_eq("rs_accepted", 160'(s_tag > 32'd150), 160'd1);
        check_eq("rf_accepted", 160'(f_tag > 32'd550), 160'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
